// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: default datapath and register
// widths, and the operand-forwarding select codes used by the EX stage.
package mips_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    // Operand source select for the EX-stage ALU input muxes
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEM_WB  = 2'b01,
        FWD_EX_MEM  = 2'b10
    } fwd_sel_e;

    // EX/MEM holds the newer result, so its hit outranks a MEM/WB hit
    function automatic logic [1:0] fwd_pick(input logic ex_mem_hit, input logic mem_wb_hit);
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (ex_mem_hit) begin
            sel = FWD_EX_MEM;
        end else if (mem_wb_hit) begin
            sel = FWD_MEM_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ex_mem_stage_forwarding_unit.sv
// forwarding_unit: purely combinational source-register compare that picks
// where each EX operand should come from. Register $0 is never forwarded.
module forwarding_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             ex_mem_valid,
    input  logic             ex_mem_reg_write,
    input  logic [REG_W-1:0] ex_mem_write_reg,
    input  logic             mem_wb_reg_write,
    input  logic [REG_W-1:0] mem_wb_write_reg,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

    logic ex_mem_src;
    logic mem_wb_src;

    assign ex_mem_src = ex_mem_valid && ex_mem_reg_write && (ex_mem_write_reg != '0);
    assign mem_wb_src = mem_wb_reg_write && (mem_wb_write_reg != '0);

    // Per-operand hit detection and priority selection
    always_comb begin
        forward_a = fwd_pick(ex_mem_src && (ex_mem_write_reg == rs),
                             mem_wb_src && (mem_wb_write_reg == rs));
        forward_b = fwd_pick(ex_mem_src && (ex_mem_write_reg == rt),
                             mem_wb_src && (mem_wb_write_reg == rt));
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with hazard-unit stall/flush, plus
// the EX-stage forwarding selects. Define FORWARDING_EN to build the
// forwarding compare; without it Forward_A/Forward_B are tied to register
// file and the hazard unit must stall on every RAW dependency.
module ex_mem_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ALU_Result_In,
    input  logic [DATA_W-1:0] Write_Data_In,
    input  logic [REG_W-1:0]  Write_Reg_In,
    input  logic              RegWrite_In,
    input  logic              MemRead_In,
    input  logic              MemWrite_In,
    input  logic              MemToReg_In,
    input  logic [REG_W-1:0]  ID_EX_Rs,
    input  logic [REG_W-1:0]  ID_EX_Rt,
    input  logic [REG_W-1:0]  MEM_WB_Write_Reg,
    input  logic              MEM_WB_RegWrite,
    output logic [DATA_W-1:0] ALU_Result_Out,
    output logic [DATA_W-1:0] Write_Data_Out,
    output logic [REG_W-1:0]  Write_Reg_Out,
    output logic              RegWrite_Out,
    output logic              MemRead_Out,
    output logic              MemWrite_Out,
    output logic              MemToReg_Out,
    output logic              Valid_Out,
    output logic [1:0]        Forward_A,
    output logic [1:0]        Forward_B
);

    logic [DATA_W-1:0] alu_result_p0;
    logic [DATA_W-1:0] write_data_p0;
    logic [REG_W-1:0]  write_reg_p0;
    logic              reg_write_p0;
    logic              mem_read_p0;
    logic              mem_write_p0;
    logic              mem_to_reg_p0;
    logic              vld_p0;

    // ---- EX -> MEM boundary ----
    // Priority Reset > Flush > Stall > load; a flush inserts an all-zero bubble
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            alu_result_p0 <= '0;
            write_data_p0 <= '0;
            write_reg_p0  <= '0;
            reg_write_p0  <= 1'b0;
            mem_read_p0   <= 1'b0;
            mem_write_p0  <= 1'b0;
            mem_to_reg_p0 <= 1'b0;
            vld_p0        <= 1'b0;
        end else if (!Stall) begin
            alu_result_p0 <= ALU_Result_In;
            write_data_p0 <= Write_Data_In;
            write_reg_p0  <= Write_Reg_In;
            reg_write_p0  <= RegWrite_In;
            mem_read_p0   <= MemRead_In;
            mem_write_p0  <= MemWrite_In;
            mem_to_reg_p0 <= MemToReg_In;
            vld_p0        <= 1'b1;
        end
    end

    assign ALU_Result_Out = alu_result_p0;
    assign Write_Data_Out = write_data_p0;
    assign Write_Reg_Out  = write_reg_p0;
    assign RegWrite_Out   = reg_write_p0;
    assign MemRead_Out    = mem_read_p0;
    assign MemWrite_Out   = mem_write_p0;
    assign MemToReg_Out   = mem_to_reg_p0;
    assign Valid_Out      = vld_p0;

`ifdef FORWARDING_EN
    // Compare against the registered EX/MEM slot and the MEM/WB destination
    forwarding_unit #(
        .REG_W (REG_W)
    ) u_forwarding_unit (
        .ex_mem_valid     (vld_p0),
        .ex_mem_reg_write (reg_write_p0),
        .ex_mem_write_reg (write_reg_p0),
        .mem_wb_reg_write (MEM_WB_RegWrite),
        .mem_wb_write_reg (MEM_WB_Write_Reg),
        .rs               (ID_EX_Rs),
        .rt               (ID_EX_Rt),
        .forward_a        (Forward_A),
        .forward_b        (Forward_B)
    );
`else
    // No forwarding hardware: operands always come from the register file
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ID_EX_Rs, ID_EX_Rt, MEM_WB_Write_Reg, MEM_WB_RegWrite};
    assign Forward_A = FWD_REGFILE;
    assign Forward_B = FWD_REGFILE;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage. Forwarding expectations follow the
// build: with FORWARDING_EN the compare rules apply, otherwise selects are 00.
module tb_ex_mem_stage;

`ifdef FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic [31:0] ALU_Result_In;
    logic [31:0] Write_Data_In;
    logic [4:0]  Write_Reg_In;
    logic        RegWrite_In;
    logic        MemRead_In;
    logic        MemWrite_In;
    logic        MemToReg_In;
    logic [4:0]  ID_EX_Rs;
    logic [4:0]  ID_EX_Rt;
    logic [4:0]  MEM_WB_Write_Reg;
    logic        MEM_WB_RegWrite;
    logic [31:0] ALU_Result_Out;
    logic [31:0] Write_Data_Out;
    logic [4:0]  Write_Reg_Out;
    logic        RegWrite_Out;
    logic        MemRead_Out;
    logic        MemWrite_Out;
    logic        MemToReg_Out;
    logic        Valid_Out;
    logic [1:0]  Forward_A;
    logic [1:0]  Forward_B;

    int checks;
    int failures;

    ex_mem_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .ALU_Result_In    (ALU_Result_In),
        .Write_Data_In    (Write_Data_In),
        .Write_Reg_In     (Write_Reg_In),
        .RegWrite_In      (RegWrite_In),
        .MemRead_In       (MemRead_In),
        .MemWrite_In      (MemWrite_In),
        .MemToReg_In      (MemToReg_In),
        .ID_EX_Rs         (ID_EX_Rs),
        .ID_EX_Rt         (ID_EX_Rt),
        .MEM_WB_Write_Reg (MEM_WB_Write_Reg),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .ALU_Result_Out   (ALU_Result_Out),
        .Write_Data_Out   (Write_Data_Out),
        .Write_Reg_Out    (Write_Reg_Out),
        .RegWrite_Out     (RegWrite_Out),
        .MemRead_Out      (MemRead_Out),
        .MemWrite_Out     (MemWrite_Out),
        .MemToReg_Out     (MemToReg_Out),
        .Valid_Out        (Valid_Out),
        .Forward_A        (Forward_A),
        .Forward_B        (Forward_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd_exp(input logic [1:0] sel);
        return FWD_ON ? {30'd0, sel} : 32'd0;
    endfunction

    // One clock edge, then land on the falling edge for sampling/driving
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic load(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
        ALU_Result_In = alu;
        Write_Data_In = wd;
        Write_Reg_In  = wr;
        RegWrite_In   = rw;
        MemRead_In    = mr;
        MemWrite_In   = mw;
        MemToReg_In   = m2r;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        load(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd0; MEM_WB_Write_Reg = 5'd0; MEM_WB_RegWrite = 1'b0;
        @(negedge Clk);
        step();
        step();

        // Reset state
        chk("rst_alu",   ALU_Result_Out, 32'h0);
        chk("rst_wreg",  {27'd0, Write_Reg_Out}, 32'd0);
        chk("rst_rw",    {31'd0, RegWrite_Out}, 32'd0);
        chk("rst_valid", {31'd0, Valid_Out}, 32'd0);
        chk("rst_fa",    {30'd0, Forward_A}, 32'd0);

        // First load
        Reset = 1'b0;
        load(32'h0000_00AA, 32'h1234_5678, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("ld_alu",   ALU_Result_Out, 32'h0000_00AA);
        chk("ld_wd",    Write_Data_Out, 32'h1234_5678);
        chk("ld_wreg",  {27'd0, Write_Reg_Out}, 32'd9);
        chk("ld_rw",    {31'd0, RegWrite_Out}, 32'd1);
        chk("ld_mr",    {31'd0, MemRead_Out}, 32'd1);
        chk("ld_m2r",   {31'd0, MemToReg_Out}, 32'd1);
        chk("ld_valid", {31'd0, Valid_Out}, 32'd1);

        // Stall holds for three cycles while inputs change
        Stall = 1'b1;
        load(32'h0000_0055, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu",  ALU_Result_Out, 32'h0000_00AA);
            chk("stall_wreg", {27'd0, Write_Reg_Out}, 32'd9);
            chk("stall_mw",   {31'd0, MemWrite_Out}, 32'd0);
        end
        Stall = 1'b0;
        step();
        chk("unstall_alu",  ALU_Result_Out, 32'h0000_0055);
        chk("unstall_wreg", {27'd0, Write_Reg_Out}, 32'd3);
        chk("unstall_mw",   {31'd0, MemWrite_Out}, 32'd1);

        // Flush beats Stall
        Flush = 1'b1; Stall = 1'b1;
        load(32'h0000_0077, 32'h0000_0011, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("flush_alu",   ALU_Result_Out, 32'h0);
        chk("flush_wd",    Write_Data_Out, 32'h0);
        chk("flush_wreg",  {27'd0, Write_Reg_Out}, 32'd0);
        chk("flush_rw",    {31'd0, RegWrite_Out}, 32'd0);
        chk("flush_mw",    {31'd0, MemWrite_Out}, 32'd0);
        chk("flush_valid", {31'd0, Valid_Out}, 32'd0);

        // Forwarding: EX/MEM dest 9 outranks MEM/WB dest 9
        Flush = 1'b0; Stall = 1'b0;
        load(32'h0000_0100, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        ID_EX_Rs = 5'd9; ID_EX_Rt = 5'd9; MEM_WB_Write_Reg = 5'd9; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("fwd_both_a", {30'd0, Forward_A}, fwd_exp(2'b10));
        chk("fwd_both_b", {30'd0, Forward_B}, fwd_exp(2'b10));
        ID_EX_Rt = 5'd4; MEM_WB_Write_Reg = 5'd4;
        #1;
        chk("fwd_mix_a", {30'd0, Forward_A}, fwd_exp(2'b10));
        chk("fwd_mix_b", {30'd0, Forward_B}, fwd_exp(2'b01));

        // Destination $0 is never forwarded
        @(negedge Clk);
        load(32'h0000_0200, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        ID_EX_Rs = 5'd0; ID_EX_Rt = 5'd4; MEM_WB_Write_Reg = 5'd4; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("fwd_r0_a", {30'd0, Forward_A}, fwd_exp(2'b00));
        chk("fwd_wb_b", {30'd0, Forward_B}, fwd_exp(2'b01));
        MEM_WB_Write_Reg = 5'd0; ID_EX_Rt = 5'd0;
        #1;
        chk("fwd_wb_r0_b", {30'd0, Forward_B}, fwd_exp(2'b00));

        // EX/MEM not writing: MEM/WB supplies the value
        @(negedge Clk);
        load(32'h0000_0300, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        ID_EX_Rs = 5'd7; ID_EX_Rt = 5'd7; MEM_WB_Write_Reg = 5'd7; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("fwd_norw_a", {30'd0, Forward_A}, fwd_exp(2'b01));
        MEM_WB_RegWrite = 1'b0;
        #1;
        chk("fwd_none_b", {30'd0, Forward_B}, fwd_exp(2'b00));

        // Bubble in EX/MEM (Valid_Out=0) must not forward even with stale match
        @(negedge Clk);
        load(32'h0000_0400, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        #1;
        chk("fwd_bubble_a", {30'd0, Forward_A}, fwd_exp(2'b00));

        // Reset asserted mid-stall clears state
        @(negedge Clk);
        load(32'h0000_0500, 32'h0000_0600, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst_alu", ALU_Result_Out, 32'h0000_0500);
        Stall = 1'b1; Reset = 1'b1;
        step();
        chk("rst_stall_alu",   ALU_Result_Out, 32'h0);
        chk("rst_stall_valid", {31'd0, Valid_Out}, 32'd0);
        Reset = 1'b0; Stall = 1'b0;
        step();
        chk("post_rst_alu",   ALU_Result_Out, 32'h0000_0500);
        chk("post_rst_valid", {31'd0, Valid_Out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
